z_test_scheduler: RTL

//  Sequences the z_buffer depth-test unit for the rasteriser back end.

---
 rtl/zbuf_pkg.sv | 38 +++
 rtl/zbuf_frag_fifo.sv | 53 +++++
 rtl/z_test_scheduler.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/zbuf_pkg.sv
// Shared types for the z-buffer depth-test scheduler: depth functions, FSM states
// and the default fragment record.
package zbuf_pkg;

    localparam int Z_SIZE_DEF       = 8;
    localparam int X_PIXEL_SIZE_DEF = 2;
    localparam int Y_PIXEL_SIZE_DEF = 2;
    localparam int COLOR_SIZE_DEF   = 16;

    typedef enum logic [2:0] {
        Z_NEVER    = 3'd0,
        Z_LESS     = 3'd1,
        Z_EQUAL    = 3'd2,
        Z_LEQUAL   = 3'd3,
        Z_GREATER  = 3'd4,
        Z_NOTEQUAL = 3'd5,
        Z_GEQUAL   = 3'd6,
        Z_ALWAYS   = 3'd7
    } z_func_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT      = 3'd2,
        S_OUT       = 3'd3,
        S_CLR_ISSUE = 3'd4,
        S_CLR_WAIT  = 3'd5
    } sched_state_t;

    typedef struct packed {
        logic [X_PIXEL_SIZE_DEF-1:0] x;
        logic [Y_PIXEL_SIZE_DEF-1:0] y;
        logic [Z_SIZE_DEF-1:0]       z;
        z_func_t                     func;
        logic [COLOR_SIZE_DEF-1:0]   color;
    } frag_t;

endpackage

// File: rtl/zbuf_frag_fifo.sv
// Synchronous fragment FIFO with full/empty flags; the head entry is visible on
// data_o whenever the FIFO is non-empty.
module zbuf_frag_fifo
    import zbuf_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = frag_t
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit separates the full and empty cases.
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    entry_t      mem_reg [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_reg == rd_ptr_reg);
    assign full_o  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_reg[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_reg[wr_ptr_reg[AW-1:0]] <= data_i;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/z_test_scheduler.sv
// Queues fragments and issues them one at a time to the z_buffer depth test,
// forwarding passing fragments and serialising depth-buffer clears behind them.
module z_test_scheduler
    import zbuf_pkg::*;
#(
    parameter int Z_SIZE       = 8,
    parameter int X_RES        = 4,
    parameter int Y_RES        = 4,
    parameter int X_PIXEL_SIZE = $clog2(X_RES),
    parameter int Y_PIXEL_SIZE = $clog2(Y_RES),
    parameter int COLOR_SIZE   = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_SIZE     = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    frag_valid_i,
    output logic                    frag_ready_o,
    input  logic [X_PIXEL_SIZE-1:0] frag_x_i,
    input  logic [Y_PIXEL_SIZE-1:0] frag_y_i,
    input  logic [Z_SIZE-1:0]       frag_z_i,
    input  logic [2:0]              frag_func_i,
    input  logic [COLOR_SIZE-1:0]   frag_color_i,
    input  logic                    clear_req_i,
    output logic                    clear_ack_o,
    output logic                    zb_start_o,
    output logic                    zb_flush_o,
    output logic [X_PIXEL_SIZE-1:0] zb_pixel_x_o,
    output logic [Y_PIXEL_SIZE-1:0] zb_pixel_y_o,
    output logic [Z_SIZE-1:0]       zb_pixel_z_o,
    output logic [2:0]              zb_func_o,
    input  logic                    zb_done_i,
    input  logic                    zb_depth_pass_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [X_PIXEL_SIZE-1:0] out_x_o,
    output logic [Y_PIXEL_SIZE-1:0] out_y_o,
    output logic [COLOR_SIZE-1:0]   out_color_o,
    output logic [CNT_SIZE-1:0]     pass_cnt_o,
    output logic [CNT_SIZE-1:0]     fail_cnt_o,
    output logic                    busy_o
);

    typedef struct packed {
        logic [X_PIXEL_SIZE-1:0] x;
        logic [Y_PIXEL_SIZE-1:0] y;
        logic [Z_SIZE-1:0]       z;
        z_func_t                 func;
        logic [COLOR_SIZE-1:0]   color;
    } frag_entry_t;

    sched_state_t        state_reg;
    sched_state_t        state_next;
    frag_entry_t         fifo_in;
    frag_entry_t         fifo_head;
    frag_entry_t         inflight_reg;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                clear_pend_reg;
    logic                clear_pend_next;
    logic                clear_done;
    logic                zb_start_reg;
    logic                zb_start_next;
    logic                zb_flush_reg;
    logic                zb_flush_next;
    logic                out_valid_reg;
    logic                out_valid_next;
    logic                clear_ack_reg;
    logic                clear_ack_next;
    logic                pass_inc;
    logic                fail_inc;
    logic [CNT_SIZE-1:0] pass_cnt_reg;
    logic [CNT_SIZE-1:0] fail_cnt_reg;

    // A pending clear blocks new fragments so the flush cannot be overtaken.
    assign frag_ready_o = !fifo_full && !clear_pend_reg;
    assign push         = frag_valid_i && frag_ready_o;

    always_comb begin
        fifo_in       = '0;
        fifo_in.x     = frag_x_i;
        fifo_in.y     = frag_y_i;
        fifo_in.z     = frag_z_i;
        fifo_in.func  = z_func_t'(frag_func_i);
        fifo_in.color = frag_color_i;
    end

    zbuf_frag_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (frag_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (fifo_in),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_next     = state_reg;
        pop            = 1'b0;
        zb_start_next  = 1'b0;
        zb_flush_next  = zb_flush_reg;
        out_valid_next = out_valid_reg;
        clear_ack_next = 1'b0;
        clear_done     = 1'b0;
        pass_inc       = 1'b0;
        fail_inc       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Queued fragments always drain ahead of a pending clear.
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = S_ISSUE;
                end else if (clear_pend_reg) begin
                    state_next = S_CLR_ISSUE;
                end
            end
            S_ISSUE: begin
                zb_start_next = 1'b1;
                zb_flush_next = 1'b0;
                state_next    = S_WAIT;
            end
            S_WAIT: begin
                if (zb_done_i) begin
                    if (zb_depth_pass_i) begin
                        pass_inc       = 1'b1;
                        out_valid_next = 1'b1;
                        state_next     = S_OUT;
                    end else begin
                        fail_inc   = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    out_valid_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end
            S_CLR_ISSUE: begin
                zb_start_next = 1'b1;
                zb_flush_next = 1'b1;
                state_next    = S_CLR_WAIT;
            end
            S_CLR_WAIT: begin
                if (zb_done_i) begin
                    clear_ack_next = 1'b1;
                    zb_flush_next  = 1'b0;
                    clear_done     = 1'b1;
                    state_next     = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Requests arriving while a clear is pending fold into it.
    assign clear_pend_next = clear_done ? 1'b0 : (clear_pend_reg || clear_req_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= S_IDLE;
            inflight_reg   <= '0;
            clear_pend_reg <= 1'b0;
            zb_start_reg   <= 1'b0;
            zb_flush_reg   <= 1'b0;
            out_valid_reg  <= 1'b0;
            clear_ack_reg  <= 1'b0;
            pass_cnt_reg   <= '0;
            fail_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            clear_pend_reg <= clear_pend_next;
            zb_start_reg   <= zb_start_next;
            zb_flush_reg   <= zb_flush_next;
            out_valid_reg  <= out_valid_next;
            clear_ack_reg  <= clear_ack_next;
            if (pop) begin
                inflight_reg <= fifo_head;
            end
            if (pass_inc && (pass_cnt_reg != '1)) begin
                pass_cnt_reg <= pass_cnt_reg + CNT_SIZE'(1);
            end
            if (fail_inc && (fail_cnt_reg != '1)) begin
                fail_cnt_reg <= fail_cnt_reg + CNT_SIZE'(1);
            end
        end
    end

    // Operands and payload come straight from the in-flight register, which only
    // reloads in S_IDLE, so they stay stable across start..done and while out_valid.
    assign zb_start_o   = zb_start_reg;
    assign zb_flush_o   = zb_flush_reg;
    assign zb_pixel_x_o = inflight_reg.x;
    assign zb_pixel_y_o = inflight_reg.y;
    assign zb_pixel_z_o = inflight_reg.z;
    assign zb_func_o    = inflight_reg.func;
    assign out_valid_o  = out_valid_reg;
    assign out_x_o      = inflight_reg.x;
    assign out_y_o      = inflight_reg.y;
    assign out_color_o  = inflight_reg.color;
    assign clear_ack_o  = clear_ack_reg;
    assign pass_cnt_o   = pass_cnt_reg;
    assign fail_cnt_o   = fail_cnt_reg;
    assign busy_o       = (state_reg != S_IDLE) || !fifo_empty || clear_pend_reg;

endmodule
